// File: rtl/axi_ar_xbar_rr.sv
// AXI read-address crossbar: round-robin arbitration over NUM_M masters, table-driven
// decode onto NUM_S slaves or a DECERR target, through one registered output slot.
module axi_ar_xbar_rr #(
   parameter int NUM_M  = 3,
   parameter int NUM_S  = 6,
   parameter int ID_W   = 4,
   parameter int TAG_W  = 4,
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 4,
   parameter int SIZE_W = 3,
   parameter logic [NUM_S*ADDR_W-1:0] S_BASE = {
      32'h2000_0000, 32'h1000_0000, 32'h0002_0000,
      32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
   parameter logic [NUM_S*ADDR_W-1:0] S_MASK = {
      32'hF000_0000, 32'hF000_0000, 32'hFFFE_0000,
      32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000},
   localparam int IDS_W = TAG_W + ID_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_M*ID_W-1:0]    ARID_M,
   input  logic [NUM_M*ADDR_W-1:0]  ARADDR_M,
   input  logic [NUM_M*LEN_W-1:0]   ARLEN_M,
   input  logic [NUM_M*SIZE_W-1:0]  ARSIZE_M,
   input  logic [NUM_M*2-1:0]       ARBURST_M,
   input  logic [NUM_M-1:0]         ARVALID_M,
   output logic [NUM_M-1:0]         ARREADY_M,
   output logic [IDS_W-1:0]         ARID_S,
   output logic [ADDR_W-1:0]        ARADDR_S,
   output logic [LEN_W-1:0]         ARLEN_S,
   output logic [SIZE_W-1:0]        ARSIZE_S,
   output logic [1:0]               ARBURST_S,
   output logic [NUM_S-1:0]         ARVALID_S,
   input  logic [NUM_S-1:0]         ARREADY_S,
   output logic                     DEC_VALID,
   input  logic                     DEC_READY
);

   localparam int PTR_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int SEL_W = (NUM_S > 1) ? $clog2(NUM_S) : 1;

   typedef enum logic {EMPTY, FULL} slot_e;

   slot_e              r_state, w_nextState;
   logic [PTR_W-1:0]   r_ptr, w_grant;
   logic [SEL_W-1:0]   r_sel, w_decSel;
   logic               r_miss;
   logic [IDS_W-1:0]   r_id;
   logic [ADDR_W-1:0]  r_addr, w_addr;
   logic [LEN_W-1:0]   r_len;
   logic [SIZE_W-1:0]  r_size;
   logic [1:0]         r_burst;
   logic [TAG_W-1:0]   w_tag;
   logic               w_anyValid, w_hit, w_targetReady, w_drain, w_canAccept, w_accept;

   always_comb begin
      int idx;
      idx        = 0;
      w_grant    = '0;
      w_anyValid = 1'b0;
      for (int k = 0; k < NUM_M; k++) begin
         idx = (int'(r_ptr) + k) % NUM_M;
         if (!w_anyValid && ARVALID_M[idx]) begin
            w_anyValid = 1'b1;
            w_grant    = PTR_W'(idx);
         end
      end
   end

   assign w_addr = ARADDR_M[w_grant*ADDR_W +: ADDR_W];
   assign w_tag  = TAG_W'(1) << w_grant;

   // Scanning downward lets the lowest-index matching window win on overlaps.
   always_comb begin
      w_hit    = 1'b0;
      w_decSel = '0;
      for (int s = NUM_S-1; s >= 0; s--) begin
         if ((w_addr & S_MASK[s*ADDR_W +: ADDR_W]) == S_BASE[s*ADDR_W +: ADDR_W]) begin
            w_hit    = 1'b1;
            w_decSel = SEL_W'(s);
         end
      end
   end

   assign w_targetReady = r_miss ? DEC_READY : ARREADY_S[r_sel];
   assign w_drain       = (r_state == FULL) && w_targetReady;
   assign w_canAccept   = (r_state == EMPTY) || w_drain;
   assign w_accept      = rst && w_canAccept && w_anyValid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= EMPTY;
      else      r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      if (w_accept)     w_nextState = FULL;
      else if (w_drain) w_nextState = EMPTY;
   end

   always_comb begin
      ARREADY_M = '0;
      ARVALID_S = '0;
      DEC_VALID = 1'b0;
      if (w_accept) ARREADY_M[w_grant] = 1'b1;
      if (r_state == FULL) begin
         if (r_miss) DEC_VALID = 1'b1;
         else        ARVALID_S[r_sel] = 1'b1;
      end
   end

   // Slot payload and pointer only move on an accept, so an idle master keeps its turn.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr   <= '0;
         r_id    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_size  <= '0;
         r_burst <= '0;
         r_sel   <= '0;
         r_miss  <= 1'b0;
      end else if (w_accept) begin
         r_ptr   <= (int'(w_grant) == NUM_M-1) ? '0 : w_grant + 1'b1;
         r_id    <= {w_tag, ARID_M[w_grant*ID_W +: ID_W]};
         r_addr  <= w_addr;
         r_len   <= ARLEN_M[w_grant*LEN_W +: LEN_W];
         r_size  <= ARSIZE_M[w_grant*SIZE_W +: SIZE_W];
         r_burst <= ARBURST_M[w_grant*2 +: 2];
         r_sel   <= w_decSel;
         r_miss  <= !w_hit;
      end
   end

   assign ARID_S    = r_id;
   assign ARADDR_S  = r_addr;
   assign ARLEN_S   = r_len;
   assign ARSIZE_S  = r_size;
   assign ARBURST_S = r_burst;

endmodule

// File: doc/axi_ar_xbar_rr.md
Name: axi_ar_xbar_rr

Overview:
- Parametrised AXI read-address (AR) channel crossbar: NUM_M masters to NUM_S slaves.
- Replaces the fixed 3x6 AR path with:
  - round-robin arbitration,
  - a parameter-table address decoder,
  - a registered output slot,
  - a decode-error (DECERR) port for unmapped addresses.
- Sits in the AXI interconnect between the CPU/DMA masters and the memory/peripheral slaves. The R channel uses the prefixed ID to route responses back.

Parameters:
- NUM_M, 3, number of masters (1..TAG_W).
- NUM_S, 6, number of slaves (1..16).
- ID_W, 4, master-side ARID width.
- TAG_W, 4, master-tag width; slave-side ID width IDS_W = TAG_W+ID_W.
- ADDR_W, 32, address width.
- LEN_W, 4, ARLEN width.
- SIZE_W, 3, ARSIZE width.
- S_BASE, see ports, NUM_S*ADDR_W packed base addresses; slave s occupies slice [s*ADDR_W +: ADDR_W].
- S_MASK, see ports, NUM_S*ADDR_W packed masks. Slave s hits when (ARADDR & mask_s) == base_s. The lowest-index hit wins.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- ARID_M  in  NUM_M*ID_W  per-master ID.
- ARADDR_M  in  NUM_M*ADDR_W  per-master address.
- ARLEN_M  in  NUM_M*LEN_W  per-master burst length.
- ARSIZE_M  in  NUM_M*SIZE_W  per-master burst size.
- ARBURST_M  in  NUM_M*2  per-master burst type.
- ARVALID_M  in  NUM_M  per-master valid.
- ARREADY_M  out  NUM_M  per-master ready.
- ARID_S  out  IDS_W  slave ID, shared by all slaves: {one-hot master tag, ARID}.
- ARADDR_S / ARLEN_S / ARSIZE_S / ARBURST_S  out  ADDR_W / LEN_W / SIZE_W / 2  shared payload to all slaves.
- ARVALID_S  out  NUM_S  per-slave valid.
- ARREADY_S  in  NUM_S  per-slave ready.
- DEC_VALID  out  1  unmapped request to the default (DECERR) slave.
- DEC_READY  in  1  default slave accept.

Behaviour:
Reset:
- Output values while rst=0:
  - ARVALID_S=0, DEC_VALID=0, ARREADY_M=0.
  - ARID_S/ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S=0.
  - Round-robin pointer=0.
  - Slot empty.
- Reset mid-transfer drops the slot with no handshake completed. Masters must re-issue.

Output slot:
- One output register slot, with states EMPTY and FULL.
- drain = FULL and the selected target's ready is high. The target is ARREADY_S[sel], or DEC_READY when miss=1.
- can_accept = EMPTY or drain.

Arbitration:
- Combinational.
- Among ARVALID_M bits, grant the first set index found searching upward from ptr, wrapping NUM_M-1 -> 0.
- ARREADY_M[g] = can_accept and ARVALID_M[g]. All other ARREADY_M bits are 0.
- At most one ARREADY_M bit is high per cycle.
- ARREADY_M may depend on ARVALID_M. ARVALID_S/DEC_VALID never depend on any ready.

On accept (rising edge with ARREADY_M[g]=1):
- Slot captures:
  - ID = {tag with bit g set, ARID_M[g]},
  - ADDR, LEN, SIZE, BURST of master g,
  - sel = decoded slave index,
  - miss = no slave hit.
- State -> FULL.
- ptr <= (g+1) mod NUM_M.

While FULL:
- ARVALID_S[sel]=1, or DEC_VALID=1 if miss. Exactly one valid is high.
- Payload is stable until the handshake.

Transitions:
- On drain without a new accept -> EMPTY.
- On drain with a simultaneous accept -> stays FULL with the new request. This gives back-to-back throughput of 1 request/cycle.

Latency and fairness:
- Latency is 1 cycle from master handshake to slave valid.
- No grant while the slot is FULL and not draining. Masters keep ARVALID high per AXI.
- ptr only advances on an accept, so an idle master loses no priority.
- With NUM_M continuously valid masters, each master is granted once every NUM_M accepts.

Address decode and ID tagging:
- An address hitting multiple windows goes to the lowest s.
- A miss is never presented to any ARVALID_S.
- Unused high tag bits (index >= NUM_M) are always 0.

Test Plan:
1. Reset, then M1 ARVALID with ARADDR=0x0001_0000 (S1 window base 0x0001_0000, mask 0xFFFF_0000), ARID=4'h5 -> ARREADY_M=3'b010 same cycle. Next cycle ARVALID_S=6'b000010, ARID_S=8'h25. Slot holds while ARREADY_S1=0 for 3 cycles; payload stays stable throughout.
2. M0, M1, M2 all valid continuously, all slaves ready=1 -> grant order M0, M1, M2, M0, ... with one accept every cycle and no bubble cycles.
3. ptr=1 with only M0 and M2 valid -> M2 is granted first, then M0.
4. ARADDR=0xDEAD_0000 (no window hit) -> DEC_VALID=1 with ARVALID_S=0. Hold DEC_READY=0 for 2 cycles -> no new ARREADY_M is asserted. DEC_READY=1 -> the slot drains.
5. Overlapping windows S2/S3 both hit -> only ARVALID_S[2] is asserted.
6. Drive rst=0 asynchronously mid-cycle while FULL -> all valids and readys go 0 immediately. After release, ptr=0 and the slot is EMPTY.
